sipo_rx: RTL and testbench

SIPO_RX -- requirements
Module: sipo_rx

---
 rtl/sipo_rx.sv | 116 +++++++++++
 tb/tb_sipo_rx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: LSB-first bits are assembled into words and handed off through a holding register with a ready/taken handshake.
// Optional build macro SIPO_OVERRUN_EN: keep the old word and raise a sticky overrun flag instead of overwriting.
module sipo_rx #(
    parameter int SIPO_DATA_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sipo_data_in,
    input  logic                       sipo_data_val,
    input  logic                       data_taken,
    input  logic                       overrun_clr,
    output logic [SIPO_DATA_WIDTH-1:0] sipo_data_out,
    output logic                       data_ready,
    output logic                       frame_err,
    output logic                       overrun
);

    localparam int CW = $clog2(SIPO_DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(SIPO_DATA_WIDTH - 1);

    logic [SIPO_DATA_WIDTH-1:0] shift_q, shift_d;
    logic [SIPO_DATA_WIDTH-1:0] hold_q, hold_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       ready_q, ready_d;
    logic                       ferr_q, ferr_d;
    logic                       take;
    logic                       ovr_evt;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        ready_d = ready_q;
        ferr_d  = 1'b0;
        ovr_evt = 1'b0;
        take    = data_taken & ready_q;

        if (take) begin
            ready_d = 1'b0;
        end

        if (sipo_data_val) begin
            shift_d[cnt_q] = sipo_data_in;
            if (cnt_q == LAST_BIT) begin
                cnt_d = '0;
                // A take on the completing edge frees the slot, so it is not an overrun.
                if (!ready_q || take) begin
                    hold_d  = shift_d;
                    ready_d = 1'b1;
                end else begin
                    ovr_evt = 1'b1;
`ifndef SIPO_OVERRUN_EN
                    hold_d  = shift_d;
                    ready_d = 1'b1;
`endif
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (cnt_q != '0) begin
            cnt_d   = '0;
            shift_d = '0;
            ferr_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
        end
    end

`ifdef SIPO_OVERRUN_EN
    logic ovr_q, ovr_d;

    // Setting takes priority so an overrun coinciding with a clear is not lost.
    always_comb begin
        ovr_d = ovr_q;
        if (overrun_clr) begin
            ovr_d = 1'b0;
        end
        if (ovr_evt) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign overrun = ovr_q;
`else
    logic unused_ovr;
    assign unused_ovr = ovr_evt ^ overrun_clr;
    assign overrun    = 1'b0;
`endif

    assign sipo_data_out = hold_q;
    assign data_ready    = ready_q;
    assign frame_err     = ferr_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx: table of serial patterns plus hand-written multi-cycle corner cases.
module tb_sipo_rx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         sipo_data_in = 1'b0;
    logic         sipo_data_val = 1'b0;
    logic         data_taken = 1'b0;
    logic         overrun_clr = 1'b0;
    logic [W-1:0] sipo_data_out;
    logic         data_ready;
    logic         frame_err;
    logic         overrun;

    int checks = 0;
    int failures = 0;

    // stream lists bits in time order from bit 7 (first sent) down to bit 0 (last sent).
    typedef struct {
        logic [7:0] stream;
        logic [7:0] expWord;
    } vec_t;

    vec_t vecs[8];

    sipo_rx #(.SIPO_DATA_WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .sipo_data_in (sipo_data_in),
        .sipo_data_val(sipo_data_val),
        .data_taken   (data_taken),
        .overrun_clr  (overrun_clr),
        .sipo_data_out(sipo_data_out),
        .data_ready   (data_ready),
        .frame_err    (frame_err),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkWord(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic b, input logic v, input logic take);
        sipo_data_in  = b;
        sipo_data_val = v;
        data_taken    = take;
        @(posedge clk);
        #1;
    endtask

    task automatic sendWord(input logic [7:0] w, input bit takeOnLast);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(w[i], 1'b1, takeOnLast && (i == 7));
        end
        data_taken = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'b10110010, 8'h4D};
        vecs[1] = '{8'b10100101, 8'hA5};
        vecs[2] = '{8'b11110000, 8'h0F};
        vecs[3] = '{8'b00000001, 8'h80};
        vecs[4] = '{8'b11000000, 8'h03};
        vecs[5] = '{8'b00111100, 8'h3C};
        vecs[6] = '{8'b11111111, 8'hFF};
        vecs[7] = '{8'b00000000, 8'h00};

        #2;
        checkWord("reset_out", sipo_data_out, 8'h00);
        checkBit("reset_ready", data_ready, 1'b0);
        checkBit("reset_ferr", frame_err, 1'b0);
        checkBit("reset_ovr", overrun, 1'b0);
        #5;
        rst = 1'b1;

        // Table: each pattern completes, is checked, then consumed.
        for (int i = 0; i < 8; i++) begin
            for (int b = 7; b >= 0; b--) begin
                applyStimulus(vecs[i].stream[b], 1'b1, 1'b0);
            end
            checkWord($sformatf("table%0d_out", i), sipo_data_out, vecs[i].expWord);
            checkBit($sformatf("table%0d_ready", i), data_ready, 1'b1);
            checkBit($sformatf("table%0d_ferr", i), frame_err, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b1);
            checkBit($sformatf("table%0d_taken", i), data_ready, 1'b0);
            checkWord($sformatf("table%0d_hold", i), sipo_data_out, vecs[i].expWord);
        end

        // Take while empty must leave no latent effect.
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkBit("idle_take_ready", data_ready, 1'b0);
        sendWord(8'h96, 1'b0);
        checkBit("after_idle_take_ready", data_ready, 1'b1);
        checkWord("after_idle_take_out", sipo_data_out, 8'h96);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkBit("after_idle_take_clr", data_ready, 1'b0);

        // Back-to-back words with take on the second completing edge.
        sendWord(8'hA5, 1'b0);
        checkWord("b2b_first_out", sipo_data_out, 8'hA5);
        checkBit("b2b_first_ready", data_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i[0] ? 1'b0 : 1'b0, 1'b1, 1'b0);
        end
        checkWord("b2b_mid_out", sipo_data_out, 8'hA5);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        data_taken = 1'b0;
        checkWord("b2b_second_out", sipo_data_out, 8'h30);
        checkBit("b2b_second_ready", data_ready, 1'b1);
        checkBit("b2b_no_ovr", overrun, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkBit("b2b_taken", data_ready, 1'b0);

        // Second contiguous pair using the exact words 0xA5 then 0x3C.
        sendWord(8'hA5, 1'b0);
        sendWord(8'h3C, 1'b1);
        checkWord("pair_out", sipo_data_out, 8'h3C);
        checkBit("pair_ready", data_ready, 1'b1);
        checkBit("pair_no_ovr", overrun, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkBit("pair_taken", data_ready, 1'b0);

        // Truncated word: five bits then a gap.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
        end
        checkBit("trunc_pre_ferr", frame_err, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkBit("trunc_ferr", frame_err, 1'b1);
        checkBit("trunc_ready", data_ready, 1'b0);
        checkWord("trunc_hold", sipo_data_out, 8'h3C);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkBit("trunc_ferr_pulse_end", frame_err, 1'b0);
        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
        end
        checkWord("trunc_next_out", sipo_data_out, 8'hFF);
        checkBit("trunc_next_ready", data_ready, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);

        // Completion while the holding register is still full.
        sendWord(8'h11, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkWord("ovr_first_out", sipo_data_out, 8'h11);
        sendWord(8'h22, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkBit("ovr_ready", data_ready, 1'b1);
`ifdef SIPO_OVERRUN_EN
        checkWord("ovr_kept_out", sipo_data_out, 8'h11);
        checkBit("ovr_flag", overrun, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkBit("ovr_sticky", overrun, 1'b1);
        overrun_clr = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        overrun_clr = 1'b0;
        checkBit("ovr_cleared", overrun, 1'b0);
        checkWord("ovr_after_clr_out", sipo_data_out, 8'h11);
`else
        checkWord("ovr_overwrite_out", sipo_data_out, 8'h22);
        checkBit("ovr_flag_tied", overrun, 1'b0);
        overrun_clr = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        overrun_clr = 1'b0;
        checkBit("ovr_clr_ignored", overrun, 1'b0);
        checkWord("ovr_clr_out", sipo_data_out, 8'h22);
`endif

        // Asynchronous reset between edges, four bits into a word.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
        end
        #3;
        rst = 1'b0;
        sipo_data_val = 1'b0;
        #1;
        checkWord("async_rst_out", sipo_data_out, 8'h00);
        checkBit("async_rst_ready", data_ready, 1'b0);
        checkBit("async_rst_ferr", frame_err, 1'b0);
        checkBit("async_rst_ovr", overrun, 1'b0);
        #2;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkBit("post_rst_no_ferr", frame_err, 1'b0);
        sendWord(8'h81, 1'b0);
        checkWord("post_rst_out", sipo_data_out, 8'h81);
        checkBit("post_rst_ready", data_ready, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkBit("post_rst_taken", data_ready, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
